// File: rtl/ysyx_22040038_id_stage.sv
// Instruction-decode pipeline stage: decodes one RV32I/RV64I instruction per
// handshake and holds the result in a single-entry output register.
module ysyx_22040038_id_stage #(
  parameter int unsigned XLEN = 64,
  parameter bit          RV64 = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_op,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_func3,
  output logic [6:0]      out_func7,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_imm_type,
  output logic            out_wen,
  output logic            out_illegal,
  output logic            out_ebreak
);

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpOpImm  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpOp     = 7'b0110011;
  localparam logic [6:0] OpOpImm32 = 7'b0011011;
  localparam logic [6:0] OpOp32   = 7'b0111011;
  localparam logic [6:0] OpSystem = 7'b1110011;

  localparam logic [2:0] ImmNone = 3'd0;
  localparam logic [2:0] ImmI    = 3'd1;
  localparam logic [2:0] ImmS    = 3'd2;
  localparam logic [2:0] ImmB    = 3'd3;
  localparam logic [2:0] ImmU    = 3'd4;
  localparam logic [2:0] ImmJ    = 3'd5;

  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       f7_ok;

  assign op    = in_instr[6:0];
  assign f3    = in_instr[14:12];
  assign f7    = in_instr[31:25];
  assign f7_ok = (f7 == 7'b0000000) || (f7 == 7'b0100000);

  logic                dec_illegal;
  logic                dec_wen;
  logic                dec_ebreak;
  logic [2:0]          dec_imm_type;
  logic signed [31:0]  imm32;
  logic [XLEN-1:0]     dec_imm;

  // Opcode decode: format, write enable and legality.
  always_comb begin
    dec_illegal  = 1'b0;
    dec_wen      = 1'b0;
    dec_ebreak   = 1'b0;
    dec_imm_type = ImmNone;
    case (op)
      OpLui, OpAuipc: begin
        dec_imm_type = ImmU;
        dec_wen      = 1'b1;
      end
      OpJal: begin
        dec_imm_type = ImmJ;
        dec_wen      = 1'b1;
      end
      OpJalr: begin
        dec_imm_type = ImmI;
        dec_wen      = 1'b1;
        dec_illegal  = (f3 != 3'b000);
      end
      OpLoad: begin
        dec_imm_type = ImmI;
        dec_wen      = 1'b1;
        dec_illegal  = (f3 == 3'b111) || (!RV64 && (f3 == 3'b011 || f3 == 3'b110));
      end
      OpOpImm: begin
        dec_imm_type = ImmI;
        dec_wen      = 1'b1;
      end
      OpBranch: begin
        dec_imm_type = ImmB;
        dec_illegal  = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OpStore: begin
        dec_imm_type = ImmS;
        dec_illegal  = (f3 > 3'b011) || (!RV64 && f3 == 3'b011);
      end
      OpOp: begin
        dec_wen     = 1'b1;
        dec_illegal = !f7_ok;
      end
      OpOpImm32: begin
        if (RV64) begin
          dec_imm_type = ImmI;
          dec_wen      = 1'b1;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OpOp32: begin
        if (RV64) begin
          dec_wen     = 1'b1;
          dec_illegal = !f7_ok;
        end else begin
          dec_illegal = 1'b1;
        end
      end
      OpSystem: begin
        if (in_instr == 32'h0010_0073) dec_ebreak = 1'b1;
        else                           dec_illegal = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
    if (dec_illegal || in_instr[11:7] == 5'd0) dec_wen = 1'b0;
  end

  // Immediate assembly; all formats are built at 32 bits, then sign-extended to XLEN.
  always_comb begin
    imm32 = '0;
    case (dec_imm_type)
      ImmI: imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      ImmS: imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      ImmB: imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                     in_instr[11:8], 1'b0};
      ImmU: imm32 = {in_instr[31:12], 12'b0};
      ImmJ: imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                     in_instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
    dec_imm = XLEN'(imm32);
  end

  logic accept;
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  // Output register: flush wins, then accept refills, otherwise a consumed entry empties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_pc       <= '0;
      out_op       <= '0;
      out_rd       <= '0;
      out_rs1      <= '0;
      out_rs2      <= '0;
      out_func3    <= '0;
      out_func7    <= '0;
      out_imm      <= '0;
      out_imm_type <= '0;
      out_wen      <= 1'b0;
      out_illegal  <= 1'b0;
      out_ebreak   <= 1'b0;
    end else begin
      if (flush)          out_valid <= 1'b0;
      else if (accept)    out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;
      if (accept) begin
        out_pc       <= in_pc;
        out_op       <= op;
        out_rd       <= in_instr[11:7];
        out_rs1      <= in_instr[19:15];
        out_rs2      <= in_instr[24:20];
        out_func3    <= f3;
        out_func7    <= f7;
        out_imm      <= dec_imm;
        out_imm_type <= dec_imm_type;
        out_wen      <= dec_wen;
        out_illegal  <= dec_illegal;
        out_ebreak   <= dec_ebreak;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22040038_id_stage.sv
// Directed testbench for the decode stage: XLEN=64/RV64 and XLEN=32/RV32 instances.
module tb_ysyx_22040038_id_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // 64-bit instance signals
  logic        flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc, out_pc, out_imm;
  logic [6:0]  out_op, out_func7;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [2:0]  out_func3, out_imm_type;
  logic        out_wen, out_illegal, out_ebreak;

  // 32-bit instance signals
  logic        s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [31:0] s_in_instr, s_in_pc, s_out_pc, s_out_imm;
  logic [6:0]  s_out_op, s_out_func7;
  logic [4:0]  s_out_rd, s_out_rs1, s_out_rs2;
  logic [2:0]  s_out_func3, s_out_imm_type;
  logic        s_out_wen, s_out_illegal, s_out_ebreak;

  ysyx_22040038_id_stage #(.XLEN(64), .RV64(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_op(out_op), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_func3(out_func3), .out_func7(out_func7), .out_imm(out_imm),
    .out_imm_type(out_imm_type), .out_wen(out_wen), .out_illegal(out_illegal),
    .out_ebreak(out_ebreak)
  );

  ysyx_22040038_id_stage #(.XLEN(32), .RV64(1'b0)) dut32 (
    .clk(clk), .rst(rst), .flush(s_flush), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_instr(s_in_instr), .in_pc(s_in_pc), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .out_pc(s_out_pc), .out_op(s_out_op), .out_rd(s_out_rd),
    .out_rs1(s_out_rs1), .out_rs2(s_out_rs2), .out_func3(s_out_func3),
    .out_func7(s_out_func7), .out_imm(s_out_imm), .out_imm_type(s_out_imm_type),
    .out_wen(s_out_wen), .out_illegal(s_out_illegal), .out_ebreak(s_out_ebreak)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] instr, input logic [63:0] pc);
    in_instr = instr;
    in_pc    = pc;
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic send32(input logic [31:0] instr);
    s_in_instr = instr;
    s_in_pc    = 32'h8000_0100;
    s_in_valid = 1'b1;
    cycle();
    s_in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    tests++; if ({out_pc, out_imm, out_rd, out_wen} !== '0) begin fails++; $display("FAIL reset_regs: pc=%h imm=%h rd=%0d wen=%b want all 0", out_pc, out_imm, out_rd, out_wen); end
    tests++; if (s_out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid32: got %b want 0", s_out_valid); end
    cycle();
    rst = 1'b0;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_addi();
    out_ready = 1'b1;
    send(32'h0050_0093, 64'h8000_0000);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL addi_valid: got %b want 1", out_valid); end
    tests++; if (out_rd !== 5'd1 || out_rs1 !== 5'd0) begin fails++; $display("FAIL addi_regs: rd=%0d rs1=%0d want 1 0", out_rd, out_rs1); end
    tests++; if (out_imm !== 64'd5 || out_imm_type !== 3'd1) begin fails++; $display("FAIL addi_imm: imm=%h type=%0d want 5 1", out_imm, out_imm_type); end
    tests++; if (out_wen !== 1'b1 || out_illegal !== 1'b0) begin fails++; $display("FAIL addi_wen: wen=%b ill=%b want 1 0", out_wen, out_illegal); end
    tests++; if (out_pc !== 64'h8000_0000) begin fails++; $display("FAIL addi_pc: got %h want 80000000", out_pc); end
    cycle();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL addi_drain: valid=%b want 0", out_valid); end
  endtask

  task automatic test_lui_beq();
    send(32'h1234_5137, 64'h8000_0004);
    tests++; if (out_imm !== 64'h0000_0000_1234_5000 || out_imm_type !== 3'd4) begin fails++; $display("FAIL lui_imm: imm=%h type=%0d want 12345000 4", out_imm, out_imm_type); end
    tests++; if (out_wen !== 1'b1 || out_rd !== 5'd2) begin fails++; $display("FAIL lui_wen: wen=%b rd=%0d want 1 2", out_wen, out_rd); end
    send(32'hFE20_8EE3, 64'h8000_0008);
    tests++; if (out_imm !== 64'hFFFF_FFFF_FFFF_FFFC || out_imm_type !== 3'd3) begin fails++; $display("FAIL beq_imm: imm=%h type=%0d want fffffffffffffffc 3", out_imm, out_imm_type); end
    tests++; if (out_wen !== 1'b0) begin fails++; $display("FAIL beq_wen: got %b want 0", out_wen); end
    tests++; if (out_op !== 7'h63 || out_rs1 !== 5'd1 || out_rs2 !== 5'd2 || out_func3 !== 3'd0 || out_func7 !== 7'h7f) begin fails++; $display("FAIL beq_fields: op=%h rs1=%0d rs2=%0d f3=%0d f7=%h want 63 1 2 0 7f", out_op, out_rs1, out_rs2, out_func3, out_func7); end
    send(32'hFE11_2C23, 64'h8000_000C);  // sw x1,-8(x2)
    tests++; if (out_imm !== 64'hFFFF_FFFF_FFFF_FFF8 || out_imm_type !== 3'd2 || out_wen !== 1'b0) begin fails++; $display("FAIL sw_imm: imm=%h type=%0d wen=%b want fffffffffffffff8 2 0", out_imm, out_imm_type, out_wen); end
    send(32'h0080_00EF, 64'h8000_0010);  // jal x1,8
    tests++; if (out_imm !== 64'd8 || out_imm_type !== 3'd5 || out_wen !== 1'b1) begin fails++; $display("FAIL jal_imm: imm=%h type=%0d wen=%b want 8 5 1", out_imm, out_imm_type, out_wen); end
    send(32'h0000_3083, 64'h8000_0014);  // ld x1,0(x0): legal on RV64
    tests++; if (out_illegal !== 1'b0 || out_wen !== 1'b1) begin fails++; $display("FAIL ld64: ill=%b wen=%b want 0 1", out_illegal, out_wen); end
    cycle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] instr;
    out_ready = 1'b0;
    send(32'h0010_0193, 64'h100);  // addi x3,x0,1
    in_valid = 1'b1;
    in_instr = 32'h0070_0393;
    in_pc    = 64'h200;
    for (int c = 0; c < 3; c++) begin
      cycle();
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_ready c%0d: got %b want 0", c, in_ready); end
      tests++; if (out_valid !== 1'b1 || out_rd !== 5'd3 || out_imm !== 64'd1 || out_pc !== 64'h100) begin fails++; $display("FAIL bp_hold c%0d: v=%b rd=%0d imm=%h pc=%h want 1 3 1 100", c, out_valid, out_rd, out_imm, out_pc); end
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      instr    = (32'(i + 10) << 20) | (32'(i + 4) << 7) | 32'h13;
      in_instr = instr;
      in_pc    = 64'h1000 + 64'(i * 4);
      cycle();
      tests++; if (out_valid !== 1'b1 || out_rd !== 5'(i + 4) || out_imm !== 64'(i + 10) || out_pc !== 64'h1000 + 64'(i * 4)) begin fails++; $display("FAIL b2b_%0d: v=%b rd=%0d imm=%h pc=%h want 1 %0d %0d", i, out_valid, out_rd, out_imm, out_pc, i + 4, i + 10); end
    end
    in_valid = 1'b0;
    cycle();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_end: valid=%b want 0", out_valid); end
  endtask

  task automatic test_illegal();
    send(32'hFFFF_FFFF, 64'h0);
    tests++; if (out_illegal !== 1'b1 || out_wen !== 1'b0 || out_imm !== 64'd0 || out_imm_type !== 3'd0) begin fails++; $display("FAIL ill_ones: ill=%b wen=%b imm=%h type=%0d want 1 0 0 0", out_illegal, out_wen, out_imm, out_imm_type); end
    tests++; if (out_op !== 7'h7f || out_rd !== 5'h1f || out_func7 !== 7'h7f) begin fails++; $display("FAIL ill_fields: op=%h rd=%h f7=%h want 7f 1f 7f", out_op, out_rd, out_func7); end
    send(32'h0010_0073, 64'h4);
    tests++; if (out_ebreak !== 1'b1 || out_illegal !== 1'b0 || out_wen !== 1'b0) begin fails++; $display("FAIL ebreak: eb=%b ill=%b wen=%b want 1 0 0", out_ebreak, out_illegal, out_wen); end
    send(32'h0000_0073, 64'h8);  // ecall: other SYSTEM
    tests++; if (out_ebreak !== 1'b0 || out_illegal !== 1'b1) begin fails++; $display("FAIL ecall: eb=%b ill=%b want 0 1", out_ebreak, out_illegal); end
    send(32'h0010_0013, 64'hC);
    tests++; if (out_wen !== 1'b0 || out_illegal !== 1'b0 || out_imm !== 64'd1) begin fails++; $display("FAIL addi_x0: wen=%b ill=%b imm=%h want 0 0 1", out_wen, out_illegal, out_imm); end
    send(32'h0220_80B3, 64'h10);  // func7=0000001 on OP
    tests++; if (out_illegal !== 1'b1 || out_wen !== 1'b0) begin fails++; $display("FAIL op_f7: ill=%b wen=%b want 1 0", out_illegal, out_wen); end
    send(32'h0000_4023, 64'h14);  // STORE func3=4
    tests++; if (out_illegal !== 1'b1) begin fails++; $display("FAIL st_f3: ill=%b want 1", out_illegal); end
    send(32'h0000_A063, 64'h18);  // BRANCH func3=2
    tests++; if (out_illegal !== 1'b1) begin fails++; $display("FAIL br_f3: ill=%b want 1", out_illegal); end
    send(32'h0000_10E7, 64'h1C);  // JALR func3=1
    tests++; if (out_illegal !== 1'b1 || out_wen !== 1'b0) begin fails++; $display("FAIL jalr_f3: ill=%b wen=%b want 1 0", out_illegal, out_wen); end
    send(32'h0000_003B, 64'h20);  // OP-32 legal on RV64, rd=0 so no write
    tests++; if (out_illegal !== 1'b0) begin fails++; $display("FAIL op32_64: ill=%b want 0", out_illegal); end
    cycle();
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    send(32'h0010_0193, 64'h300);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL flush_fill: valid=%b want 1", out_valid); end
    out_ready = 1'b1;
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_instr  = 32'h0070_0393;
    in_pc     = 64'h304;
    cycle();
    flush    = 1'b0;
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_drop: valid=%b want 0", out_valid); end
    cycle();
    tests++; if (out_valid !== 1'b0 || out_rd === 5'd7) begin fails++; $display("FAIL flush_leak: valid=%b rd=%0d want 0 not-7", out_valid, out_rd); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send(32'h0010_0193, 64'h400);
    #2;
    rst = 1'b1;
    #1;
    tests++; if (out_valid !== 1'b0 || out_rd !== 5'd0) begin fails++; $display("FAIL rst_async: valid=%b rd=%0d want 0 0", out_valid, out_rd); end
    cycle();
    rst = 1'b0;
    out_ready = 1'b1;
    cycle();
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL rst_after: valid=%b in_ready=%b want 0 1", out_valid, in_ready); end
  endtask

  task automatic test_rv32();
    s_out_ready = 1'b1;
    send32(32'h0000_003B);
    tests++; if (s_out_illegal !== 1'b1 || s_out_wen !== 1'b0) begin fails++; $display("FAIL rv32_op32: ill=%b wen=%b want 1 0", s_out_illegal, s_out_wen); end
    send32(32'h8000_0013);
    tests++; if (s_out_imm !== 32'hFFFF_F800 || s_out_wen !== 1'b0 || s_out_illegal !== 1'b0) begin fails++; $display("FAIL rv32_imm: imm=%h wen=%b ill=%b want fffff800 0 0", s_out_imm, s_out_wen, s_out_illegal); end
    send32(32'h0000_3083);
    tests++; if (s_out_illegal !== 1'b1) begin fails++; $display("FAIL rv32_ld: ill=%b want 1", s_out_illegal); end
    send32(32'h1234_5137);
    tests++; if (s_out_imm !== 32'h1234_5000 || s_out_pc !== 32'h8000_0100 || s_out_valid !== 1'b1) begin fails++; $display("FAIL rv32_lui: imm=%h pc=%h v=%b want 12345000 80000100 1", s_out_imm, s_out_pc, s_out_valid); end
    cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

  initial begin
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_instr = '0; in_pc = '0;
    s_flush = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b1; s_in_instr = '0; s_in_pc = '0;
    test_reset();
    test_addi();
    test_lui_beq();
    test_back_to_back();
    test_illegal();
    test_flush();
    test_reset_mid();
    test_rv32();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ysyx_22040038_id_stage.md
Name: ysyx_22040038_id_stage

Overview:
Registered instruction-decode pipeline stage for the NPC core, parametrised in XLEN (32 or 64).
- Decodes one RV32I/RV64I instruction per handshake into fields, a sign-extended immediate, the register-write enable and an illegal/ebreak flag set.
- Holds the result in a single-entry output register with valid/ready flow control.
- Sits between IF and EX.

Parameters:
XLEN, 64, datapath width; also the width of pc and immediate (32 or 64)
RV64, 1, 1 enables OP-IMM-32 and OP-32 opcodes; must be 0 when XLEN=32

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
flush  input  1  drop the held entry and any accepting entry this cycle
in_valid  input  1  IF presents an instruction
in_ready  output  1  stage can accept this cycle
in_instr  input  32  raw instruction
in_pc  input  XLEN  instruction address
out_valid  output  1  decoded entry held
out_ready  input  1  EX accepts the entry
out_pc  output  XLEN  registered pc
out_op  output  7  instr[6:0]
out_rd  output  5  instr[11:7]
out_rs1  output  5  instr[19:15]
out_rs2  output  5  instr[24:20]
out_func3  output  3  instr[14:12]
out_func7  output  7  instr[31:25]
out_imm  output  XLEN  immediate selected by format, sign-extended
out_imm_type  output  3  0=none 1=I 2=S 3=B 4=U 5=J
out_wen  output  1  rd write enable
out_illegal  output  1  unsupported encoding
out_ebreak  output  1  instruction is ebreak (0x00100073)

Behaviour:
Reset:
- On rst=1, asynchronously clear out_valid and every out_* register to 0.
- in_ready=1 once reset is released.

Handshake:
- in_ready = !out_valid || out_ready (combinational, no flush dependency).
- Accept occurs when in_valid && in_ready && !flush. On accept, all out_* registers load the next edge and out_valid=1. Latency is 1 cycle.
- If out_valid && out_ready and no accept occurs, out_valid clears. Data registers hold their values.
- While out_valid && !out_ready, all out_* are stable.
- flush=1 has priority: out_valid=0 next edge and the offered instruction is not captured.

Decode (combinational on in_instr, registered on accept):
- U type: LUI 0110111, AUIPC 0010111. wen=1.
- J type: JAL 1101111. wen=1.
- I type, wen=1:
  - JALR 1100111; illegal if func3!=0.
  - LOAD 0000011; illegal if func3 is 3'b111, or 3'b011/3'b110 when RV64=0.
  - OP-IMM 0010011.
- B type: BRANCH 1100011. wen=0. Illegal if func3 is 010 or 011.
- S type: STORE 0100011. wen=0. Illegal if func3>3'b011, or func3=3'b011 when RV64=0.
- R type: OP 0110011, wen=1. Illegal unless func7 is 0000000 or 0100000.
- RV64=1 only: OP-IMM-32 0011011 (I type), OP-32 0111011 (R type). wen=1.
- SYSTEM 1110011: ebreak=1 only for exactly 0x00100073. Other SYSTEM encodings are illegal. wen=0, imm_type=0.
- Any other opcode: illegal=1, wen=0, imm=0, imm_type=0.
- Whenever illegal=1, wen is forced to 0. wen is also forced to 0 when rd==0.

Immediates (sign bit is always instr[31], extended to XLEN):
- I = instr[31:20]
- S = {instr[31:25], instr[11:7]}
- B = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}
- U = {instr[31:12], 12'b0}, sign-extended from bit 31
- J = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}

Boundary conditions:
- Full with out_ready=1 and in_valid=1: drain and refill in the same edge, so out_valid stays 1.
- rst asserted mid-transfer: the held entry is discarded and nothing is emitted.
- The field outputs (op/rd/rs1/rs2/func3/func7) are raw slices, even when the instruction is illegal.

Test Plan:
1. Reset, then in_instr=0x00500093 (addi x1,x0,5), pc=0x80000000, out_ready=1 -> next cycle: out_valid=1, rd=1, rs1=0, imm=5, imm_type=1, wen=1, out_pc=0x80000000.
2. in_instr=0x12345137 (lui x2) -> imm=0x0000000012345000, imm_type=4, wen=1. Then 0xFE208EE3 (beq x1,x2,-4) -> imm=0xFFFFFFFFFFFFFFFC, imm_type=3, wen=0.
3. Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and the out_* values stay unchanged. Raise out_ready -> 1 transfer/cycle, no loss or duplication across 8 back-to-back instructions.
4. in_instr=0xFFFFFFFF -> illegal=1, wen=0, imm=0. in_instr=0x00100073 -> ebreak=1, illegal=0. addi x0,x0,1 (0x00100013) -> wen=0.
5. Flush while full and concurrently offering an instruction -> out_valid=0 next cycle and the offered instruction is never emitted. Assert rst mid-stream -> out_valid drops to 0 immediately (asynchronously).
6. XLEN=32, RV64=0: 0x0000003B (OP-32) -> illegal=1. Instruction 0x80000013 (addi x0,x0,-2048) -> imm=0xFFFFF800.
